// File: rtl/note_track_sequencer.sv
// Note-track playback sequencer: fetches note rows from RAM and paces lane shifters from the game tick.
// Optional macro SEQ_LOOP_EN: wrap to address 0 at song end instead of stopping.
module note_track_sequencer #(
  parameter int LOAD_PERIOD = 5,
  parameter int LAST_ADDR   = 127
) (
  input  logic       INPUTCLOCK,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] ram_data,
  output logic [6:0] ram_addr,
  output logic       ram_rd,
  output logic [3:0] lane_bits,
  output logic       load_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} state_t;

  localparam logic [6:0] LAST = 7'(LAST_ADDR);
  localparam logic [3:0] PMAX = 4'(LOAD_PERIOD - 1);

  state_t     state, state_nx;
  logic [3:0] phase, phase_nx;
  logic       pending, pending_nx;
  logic [6:0] addr_nx;
  logic [3:0] lane_nx;
  logic       done_nx;
  logic       accept;

  always_ff @(posedge INPUTCLOCK) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= '0;
      pending   <= 1'b0;
      ram_addr  <= '0;
      lane_bits <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      pending   <= pending_nx;
      ram_addr  <= addr_nx;
      lane_bits <= lane_nx;
      done      <= done_nx;
    end
  end

  // A held-over tick from the prefetch counts as a tick on the first RUN cycle.
  assign accept = (tick | pending) & ~pause;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    pending_nx = pending;
    addr_nx    = ram_addr;
    lane_nx    = lane_bits;
    done_nx    = 1'b0;
    ram_rd     = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = FETCH;
          addr_nx    = '0;
          phase_nx   = '0;
          pending_nx = 1'b0;
        end
      end
      FETCH: begin
        ram_rd   = 1'b1;
        state_nx = WAIT;
        if (tick) pending_nx = 1'b1;
      end
      WAIT: begin
        lane_nx  = ram_data;
        state_nx = RUN;
        if (tick) pending_nx = 1'b1;
      end
      RUN: begin
        if (accept) begin
          shift_en   = 1'b1;
          pending_nx = 1'b0;
          phase_nx   = (phase == PMAX) ? 4'd0 : phase + 4'd1;
          if (phase == 4'd0) begin
            load_en = 1'b1;
            if (ram_addr < LAST) begin
              addr_nx  = ram_addr + 7'd1;
              state_nx = FETCH;
            end else begin
              addr_nx = '0;
              done_nx = 1'b1;
`ifdef SEQ_LOOP_EN
              state_nx = FETCH;
`else
              state_nx = IDLE;
`endif
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_note_track_sequencer.sv
// Directed bench for note_track_sequencer (LOAD_PERIOD=5, LAST_ADDR=3) with a 4-row note RAM model.
module tb_note_track_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, tick, start, pause;
  logic [3:0] ram_data;
  logic [6:0] ram_addr;
  logic       ram_rd, load_en, shift_en, busy, done;
  logic [3:0] lane_bits;
  logic [3:0] mem [4];

  int n_chk = 0, n_err = 0;
  int sh_cnt = 0, ld_cnt = 0;
  logic last_sh, last_ld;

  note_track_sequencer #(.LOAD_PERIOD(5), .LAST_ADDR(3)) dut (
    .INPUTCLOCK(clk), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_rd(ram_rd), .lane_bits(lane_bits),
    .load_en(load_en), .shift_en(shift_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr[1:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive tick, sample comb strobes, advance to next falling edge.
  task automatic cyc(input logic tk);
    tick = tk;
    #1;
    last_sh = shift_en;
    last_ld = load_en;
    if (shift_en) sh_cnt++;
    if (load_en)  ld_cnt++;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    mem[0] = 4'b1010; mem[1] = 4'b0101; mem[2] = 4'b1100; mem[3] = 4'b0011;
    ram_data = '0; tick = 0; start = 0; pause = 0; reset_n = 0;
    @(negedge clk);
    repeat (3) cyc(0);
    chk("rst_addr", ram_addr, 0);   chk("rst_rd", ram_rd, 0);
    chk("rst_lane", lane_bits, 0);  chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);       chk("rst_sh", last_sh, 0);
    chk("rst_ld", last_ld, 0);

    // start -> FETCH (cycle 1), WAIT (2), RUN with row 0 (3)
    reset_n = 1;
    start = 1; cyc(0); start = 0;
    chk("c1_rd", ram_rd, 1); chk("c1_addr", ram_addr, 0); chk("c1_busy", busy, 1);
    cyc(0);
    chk("c2_rd", ram_rd, 0);
    cyc(0);
    chk("c3_lane", lane_bits, 4'b1010); chk("c3_busy", busy, 1);

    // 10 ticks 8 cycles apart: loads on ticks 1 and 6
    sh_cnt = 0; ld_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      chk($sformatf("t%0d_sh", i), last_sh, 1);
      chk($sformatf("t%0d_ld", i), last_ld, (i == 1 || i == 6));
      repeat (7) cyc(0);
      if (i == 1) begin chk("t1_addr", ram_addr, 1); chk("t1_lane", lane_bits, 4'b0101); end
      if (i == 6) begin chk("t6_addr", ram_addr, 2); chk("t6_lane", lane_bits, 4'b1100); end
    end
    chk("run_sh_cnt", sh_cnt, 10); chk("run_ld_cnt", ld_cnt, 2);

    // tick during the prefetch is held and serviced on first RUN cycle
    cyc(1);
    chk("t11_ld", last_ld, 1);
    sh_cnt = 0;
    cyc(1); chk("pend_fetch_sh", last_sh, 0);
    cyc(0); chk("pend_wait_sh", last_sh, 0);
    cyc(0); chk("pend_run_sh", last_sh, 1); chk("pend_run_ld", last_ld, 0);
    cyc(0); chk("pend_clr_sh", last_sh, 0);
    chk("pend_sh_cnt", sh_cnt, 1); chk("pend_addr", ram_addr, 3);

    // pause freezes; phase 2 held, so the 4th tick after release loads
    pause = 1; sh_cnt = 0; ld_cnt = 0;
    repeat (3) begin cyc(1); repeat (4) cyc(0); end
    chk("pause_sh_cnt", sh_cnt, 0); chk("pause_ld_cnt", ld_cnt, 0);
    pause = 0;
    for (int j = 0; j < 4; j++) begin
      cyc(1);
      chk($sformatf("res%0d_sh", j), last_sh, 1);
      chk($sformatf("res%0d_ld", j), last_ld, (j == 3));
      if (j < 3) repeat (4) cyc(0);
    end

    // final load at LAST_ADDR
    chk("end_done", done, 1); chk("end_addr", ram_addr, 0);
`ifdef SEQ_LOOP_EN
    chk("end_busy", busy, 1); chk("end_rd", ram_rd, 1);
    cyc(0); chk("end_done_clr", done, 0); chk("end_busy2", busy, 1);
`else
    chk("end_busy", busy, 0); chk("end_rd", ram_rd, 0);
    cyc(0); chk("end_done_clr", done, 0);
    repeat (3) cyc(1);
    chk("end_lane_hold", lane_bits, 4'b0011); chk("end_idle_sh", last_sh, 0);
`endif

    // start while busy ignored; reset during WAIT clears everything
    reset_n = 0; cyc(0); reset_n = 1;
    start = 1; cyc(0); start = 0;
    cyc(0); cyc(0);
    cyc(1); chk("r2_ld", last_ld, 1);
    start = 1; cyc(0); start = 0;
    chk("busy_start_addr", ram_addr, 1); chk("busy_start_busy", busy, 1);
    chk("busy_start_rd", ram_rd, 0);
    reset_n = 0; cyc(0);
    chk("wrst_addr", ram_addr, 0); chk("wrst_lane", lane_bits, 0);
    chk("wrst_busy", busy, 0);     chk("wrst_rd", ram_rd, 0);
    chk("wrst_done", done, 0);     chk("wrst_sh", last_sh, 0);
    reset_n = 1; cyc(0);
    chk("post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/note_track_sequencer.md
NOTE_TRACK_SEQUENCER -- requirements
Module: note_track_sequencer

Interface
REQ-001 SHALL have parameter LOAD_PERIOD, default 5: number of accepted ticks per note-row load; legal range 2..15.
REQ-002 SHALL have parameter LAST_ADDR, default 127: last note-RAM address played.
REQ-003 SHALL have port INPUTCLOCK  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port tick  in  1  game-rate pulse, one cycle wide, minimum spacing 4 cycles.
REQ-006 SHALL have port start  in  1  one-cycle request to begin playback at address 0.
REQ-007 SHALL have port pause  in  1  level; high freezes playback.
REQ-008 SHALL have port ram_data  in  4  lane bits from note RAM, valid the cycle after ram_rd.
REQ-009 SHALL have port ram_addr  out  7  note-RAM read address.
REQ-010 SHALL have port ram_rd  out  1  one-cycle read strobe.
REQ-011 SHALL have port lane_bits  out  4  registered row for lane shifters.
REQ-012 SHALL have port load_en  out  1  one-cycle pulse; shifters load lane_bits.
REQ-013 SHALL have port shift_en  out  1  one-cycle pulse; shifters advance one position.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle pulse at song end.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT, RUN.
REQ-017 IDLE: start=1 -> FETCH with ram_addr=0, phase=0, pending=0.
REQ-018 FETCH: ram_rd=1 for exactly one cycle at current ram_addr -> WAIT.
REQ-019 WAIT: lane_bits <= ram_data -> RUN.
REQ-020 RUN: accepted tick (tick=1 or pending=1, and pause=0) -> shift_en=1 that cycle; phase <= (phase==LOAD_PERIOD-1) ? 0 : phase+1.
REQ-021 RUN, accepted tick with phase==0 -> load_en=1 in same cycle as shift_en; load takes precedence downstream.
REQ-022 After a load with ram_addr<LAST_ADDR -> ram_addr+1, FETCH (prefetch of next row).
REQ-023 tick arriving in FETCH or WAIT SHALL set pending; pending is serviced on first RUN cycle and then cleared; a second tick while pending=1 is dropped.
REQ-024 pause=1 in RUN: tick ignored, no shift/load, phase and pending held; pause ignored in FETCH/WAIT (prefetch completes).
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 load_en, shift_en, ram_rd, done SHALL each be high at most one cycle per event.
REQ-027 Load at ram_addr==LAST_ADDR SHALL be the final load unless looping (REQ-030); next cycle done=1, state -> IDLE, ram_addr -> 0.
REQ-028 lane_bits SHALL hold its value in IDLE after song end until next WAIT.

Reset
REQ-029 reset_n=0 at a clock edge, in any state including mid-fetch: state=IDLE, ram_addr=0, phase=0, pending=0, lane_bits=0, ram_rd=load_en=shift_en=busy=done=0.

Configuration
REQ-030 Macro SEQ_LOOP_EN defined: after the load at LAST_ADDR, ram_addr wraps to 0 and FETCH continues; done pulses once per wrap, busy stays 1, stop only by reset. Undefined: behaviour per REQ-027.

Verification
REQ-031 Reset, start, ram_data=4'b1010 at addr 0 -> ram_rd at cycle 1 with addr 0, lane_bits=1010 at cycle 3, busy=1 from cycle 1.
REQ-032 RUN, 10 ticks spaced 8 cycles, LOAD_PERIOD=5 -> shift_en 10 pulses, load_en on ticks 1 and 6, ram_addr 1 then 2.
REQ-033 tick injected in the FETCH cycle after a load -> pending set, one shift_en on first RUN cycle, no tick lost.
REQ-034 pause=1 across 3 ticks -> no shift_en/load_en, phase unchanged; pause=0 then tick -> resumes at held phase.
REQ-035 LAST_ADDR=3, play to end -> load at addr 3, done=1 next cycle, busy=0, ram_addr=0; with SEQ_LOOP_EN -> next ram_rd at addr 0, busy stays 1.
REQ-036 reset_n=0 during WAIT -> all outputs 0 next cycle; start while busy -> no restart, ram_addr unchanged.
